// File: rtl/sram_arb_pkg.sv
// Shared widths and request/response record types for the SRAM front end.
package sram_arb_pkg;

  localparam int ADDR_WIDTH = 14;
  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;

  // One request as presented by an upstream port.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] address;
    logic                  read_not_write;
    logic [BE_WIDTH-1:0]   byte_enable;
    logic [DATA_WIDTH-1:0] write_data;
  } t_sram_req;

  // One read response, tagged with the port that asked for it.
  typedef struct packed {
    logic                  id;
    logic [DATA_WIDTH-1:0] data;
  } t_sram_rsp;

endpackage

// File: rtl/sram_arb_rsp_fifo.sv
// Small synchronous FIFO holding tagged read responses until the consumer
// takes them. The head entry is presented combinationally, so it stays
// stable for as long as the consumer withholds its pop.
module sram_arb_rsp_fifo
  import sram_arb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  t_sram_rsp     i_push_data,
  input  logic          i_pop,
  output t_sram_rsp     o_head,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  t_sram_rsp     r_mem [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          w_full;

  assign w_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rdPtr];

  // Storage write; contents need no reset because the count gates visibility.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wrPtr] <= i_push_data;
    end
  end

  // Pointer and occupancy tracking; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_wrPtr <= (r_wrPtr == PW'(DEPTH - 1)) ? '0 : r_wrPtr + 1'b1;
      end
      if (i_pop) begin
        r_rdPtr <= (r_rdPtr == PW'(DEPTH - 1)) ? '0 : r_rdPtr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  a_noOverflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && !i_pop && w_full));

endmodule

// File: rtl/sram_srw_32_req_arbiter.sv
// Two-port round-robin front end for the single-port byte-write SRAM.
// Requests are granted and driven onto the SRAM in the same cycle; read data
// returns one cycle later and is queued with its requester id. Reads are only
// granted while a response slot is guaranteed, counting the slot freed by a
// pop in the same cycle so back-to-back reads keep full rate.
module sram_srw_32_req_arbiter
  import sram_arb_pkg::*;
#(
  parameter int RSP_DEPTH = 2
) (
  input  logic                  sram_clock,
  input  logic                  reset_n,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_address,
  input  logic                  req0_read_not_write,
  input  logic [BE_WIDTH-1:0]   req0_byte_enable,
  input  logic [DATA_WIDTH-1:0] req0_write_data,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_address,
  input  logic                  req1_read_not_write,
  input  logic [BE_WIDTH-1:0]   req1_byte_enable,
  input  logic [DATA_WIDTH-1:0] req1_write_data,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,

  output logic                  sram_select,
  output logic                  sram_read_not_write,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic [BE_WIDTH-1:0]   sram_write_enable,
  output logic [DATA_WIDTH-1:0] sram_write_data,
  input  logic [DATA_WIDTH-1:0] sram_data_out
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int UW = CW + 1;

  t_sram_req     w_req0;
  t_sram_req     w_req1;
  t_sram_req     w_sel;
  t_sram_rsp     w_pushData;
  t_sram_rsp     w_head;
  logic [1:0]    w_elig;
  logic          w_grantValid;
  logic          w_grantId;
  logic          w_readOk;
  logic          w_pop;
  logic          w_fifoEmpty;
  logic [CW-1:0] w_fifoCount;
  logic [UW-1:0] w_used;

  logic          r_lastGrant;
  logic          r_readInFlight;
  logic          r_readId;

  assign w_req0 = '{address:        req0_address,
                    read_not_write: req0_read_not_write,
                    byte_enable:    req0_byte_enable,
                    write_data:     req0_write_data};
  assign w_req1 = '{address:        req1_address,
                    read_not_write: req1_read_not_write,
                    byte_enable:    req1_byte_enable,
                    write_data:     req1_write_data};

  assign w_pop    = !w_fifoEmpty && rsp_ready;
  assign w_used   = UW'(w_fifoCount) + UW'(r_readInFlight) - UW'(w_pop);
  assign w_readOk = (w_used < UW'(RSP_DEPTH));

  // Eligibility and round-robin grant; nothing is granted while reset is held.
  always_comb begin
    w_elig[0]    = reset_n && req0_valid && (!req0_read_not_write || w_readOk);
    w_elig[1]    = reset_n && req1_valid && (!req1_read_not_write || w_readOk);
    w_grantValid = |w_elig;
    w_grantId    = 1'b0;
    if (w_elig == 2'b11) begin
      w_grantId = ~r_lastGrant;
    end else if (w_elig[1]) begin
      w_grantId = 1'b1;
    end
    req0_ready = w_grantValid && !w_grantId;
    req1_ready = w_grantValid && w_grantId;
  end

  assign w_sel = w_grantId ? w_req1 : w_req0;

  // SRAM drive for the granted request; a zero-enable write is accepted without touching the array.
  always_comb begin
    sram_select         = 1'b0;
    sram_read_not_write = 1'b0;
    sram_address        = '0;
    sram_write_enable   = '0;
    sram_write_data     = '0;
    if (w_grantValid) begin
      sram_address        = w_sel.address;
      sram_read_not_write = w_sel.read_not_write;
      if (w_sel.read_not_write) begin
        sram_select = 1'b1;
      end else begin
        sram_select       = |w_sel.byte_enable;
        sram_write_enable = w_sel.byte_enable;
        sram_write_data   = w_sel.write_data;
      end
    end
  end

  // Grant history and the one-cycle read tracker that schedules the FIFO push.
  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lastGrant    <= 1'b1;
      r_readInFlight <= 1'b0;
      r_readId       <= 1'b0;
    end else begin
      if (w_grantValid) begin
        r_lastGrant <= w_grantId;
      end
      r_readInFlight <= w_grantValid && w_sel.read_not_write;
      r_readId       <= w_grantId;
    end
  end

  assign w_pushData = '{id: r_readId, data: sram_data_out};

  sram_arb_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rspFifo (
    .i_clk       (sram_clock),
    .i_rst_n     (reset_n),
    .i_push      (r_readInFlight),
    .i_push_data (w_pushData),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_empty     (w_fifoEmpty),
    .o_count     (w_fifoCount)
  );

  assign rsp_valid = !w_fifoEmpty;
  assign rsp_id    = w_head.id;
  assign rsp_data  = w_head.data;

endmodule

// File: tb/tb_sram_srw_32_req_arbiter.sv
// Bench for the two-port SRAM arbiter: a behavioural SRAM, directed request
// sequences, and a response scoreboard drained by an independent monitor.
module tb_sram_srw_32_req_arbiter;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } t_exp;

  logic        sramClock = 1'b0;
  logic        resetN;
  logic        req0Valid, req0Ready, req0Rnw;
  logic [13:0] req0Address;
  logic [3:0]  req0Be;
  logic [31:0] req0Data;
  logic        req1Valid, req1Ready, req1Rnw;
  logic [13:0] req1Address;
  logic [3:0]  req1Be;
  logic [31:0] req1Data;
  logic        rspValid, rspReady, rspId;
  logic [31:0] rspData;
  logic        sramSelect, sramRnw;
  logic [13:0] sramAddress;
  logic [3:0]  sramWe;
  logic [31:0] sramWd;
  logic [31:0] sramDataOut = 32'h0;

  logic [31:0] mem [0:16383];
  t_exp        expQ [$];
  int          errorCount = 0;
  int          checkCount = 0;

  // Free-running clock
  always #5 sramClock = ~sramClock;

  sram_srw_32_req_arbiter #(.RSP_DEPTH(2)) dut (
    .sram_clock          (sramClock),
    .reset_n             (resetN),
    .req0_valid          (req0Valid),
    .req0_ready          (req0Ready),
    .req0_address        (req0Address),
    .req0_read_not_write (req0Rnw),
    .req0_byte_enable    (req0Be),
    .req0_write_data     (req0Data),
    .req1_valid          (req1Valid),
    .req1_ready          (req1Ready),
    .req1_address        (req1Address),
    .req1_read_not_write (req1Rnw),
    .req1_byte_enable    (req1Be),
    .req1_write_data     (req1Data),
    .rsp_valid           (rspValid),
    .rsp_ready           (rspReady),
    .rsp_id              (rspId),
    .rsp_data            (rspData),
    .sram_select         (sramSelect),
    .sram_read_not_write (sramRnw),
    .sram_address        (sramAddress),
    .sram_write_enable   (sramWe),
    .sram_write_data     (sramWd),
    .sram_data_out       (sramDataOut)
  );

  // Behavioural SRAM: preloaded contents, registered read, byte-lane writes
  initial begin
    mem[14'h0010] = 32'hDEADBEEF;
    mem[14'h3FFF] = 32'hAABBCCDD;
    mem[14'h0100] = 32'hA0A00100;
    mem[14'h0101] = 32'hB1B10101;
    mem[14'h0102] = 32'hA2A20102;
    mem[14'h0103] = 32'hB3B30103;
    mem[14'h0104] = 32'hA4A40104;
    mem[14'h0200] = 32'hC0C00200;
    mem[14'h0201] = 32'hC1C10201;
    mem[14'h0202] = 32'hC2C20202;
    mem[14'h0300] = 32'h01020304;
    forever begin
      @(posedge sramClock);
      if (sramSelect) begin
        if (sramRnw) begin
          sramDataOut <= mem[sramAddress];
        end else begin
          for (int b = 0; b < 4; b++) begin
            if (sramWe[b]) mem[sramAddress][b*8 +: 8] <= sramWd[b*8 +: 8];
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int port, input logic valid, input logic rnw,
                               input logic [13:0] addr, input logic [3:0] be, input logic [31:0] data);
    if (port == 0) begin
      req0Valid = valid; req0Rnw = rnw; req0Address = addr; req0Be = be; req0Data = data;
    end else begin
      req1Valid = valid; req1Rnw = rnw; req1Address = addr; req1Be = be; req1Data = data;
    end
  endtask

  task automatic nextCycle();
    @(posedge sramClock);
    #1;
  endtask

  task automatic midCycle();
    @(negedge sramClock);
  endtask

  task automatic idle(input int n);
    applyStimulus(0, 1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
    for (int k = 0; k < n; k++) nextCycle();
  endtask

  // Monitor: every accepted response is compared against the oldest expectation
  initial begin
    t_exp e;
    forever begin
      @(negedge sramClock);
      if (resetN && rspValid && rspReady) begin
        if (expQ.size() == 0) begin
          checkCount++;
          errorCount++;
          $display("[TB] FAIL unexpected_rsp: got id=%0d data=%h expected no response", rspId, rspData);
        end else begin
          e = expQ.pop_front();
          checkOutput("rsp_id", {31'h0, rspId}, {31'h0, e.id});
          checkOutput("rsp_data", rspData, e.data);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  logic [13:0] t3Addr0 [4] = '{14'h0100, 14'h0102, 14'h0102, 14'h0104};
  logic [13:0] t3Addr1 [4] = '{14'h0101, 14'h0101, 14'h0103, 14'h0103};
  logic        t3Grant [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] t3Data  [4] = '{32'hA0A00100, 32'hB1B10101, 32'hA2A20102, 32'hB3B30103};

  // Directed test sequence
  initial begin
    int waitCycles;
    resetN   = 1'b0;
    rspReady = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
    nextCycle();
    midCycle();
    checkOutput("reset_rsp_valid", {31'h0, rspValid}, 32'h0);
    checkOutput("reset_ready", {30'h0, req1Ready, req0Ready}, 32'h0);
    checkOutput("reset_sram_ctl", {30'h0, sramSelect, sramRnw}, 32'h0);
    checkOutput("reset_sram_addr", {18'h0, sramAddress}, 32'h0);
    checkOutput("reset_sram_we", {28'h0, sramWe}, 32'h0);
    nextCycle();
    resetN = 1'b1;
    nextCycle();

    // Test 1: single read
    $display("[TB] test 1 single read");
    applyStimulus(0, 1'b1, 1'b1, 14'h0010, 4'h0, 32'h0);
    midCycle();
    checkOutput("t1_ready0", {31'h0, req0Ready}, 32'h1);
    checkOutput("t1_sram_select", {31'h0, sramSelect}, 32'h1);
    checkOutput("t1_sram_rnw", {31'h0, sramRnw}, 32'h1);
    checkOutput("t1_sram_addr", {18'h0, sramAddress}, 32'h0010);
    checkOutput("t1_sram_we", {28'h0, sramWe}, 32'h0);
    expQ.push_back('{id: 1'b0, data: 32'hDEADBEEF});
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
    midCycle();
    checkOutput("t1_rsp_valid_c2", {31'h0, rspValid}, 32'h0);
    nextCycle();
    midCycle();
    checkOutput("t1_rsp_valid_c3", {31'h0, rspValid}, 32'h1);
    nextCycle();
    idle(2);

    // Test 2: byte write then read back
    $display("[TB] test 2 byte write");
    applyStimulus(1, 1'b1, 1'b0, 14'h3FFF, 4'b0101, 32'h11223344);
    midCycle();
    checkOutput("t2_ready1", {31'h0, req1Ready}, 32'h1);
    checkOutput("t2_sram_ctl", {30'h0, sramSelect, sramRnw}, 32'h2);
    checkOutput("t2_sram_we", {28'h0, sramWe}, 32'h5);
    checkOutput("t2_sram_wd", sramWd, 32'h11223344);
    nextCycle();
    applyStimulus(1, 1'b1, 1'b1, 14'h3FFF, 4'h0, 32'h0);
    midCycle();
    checkOutput("t2_read_ready1", {31'h0, req1Ready}, 32'h1);
    expQ.push_back('{id: 1'b1, data: 32'hAA22CC44});
    nextCycle();
    idle(4);

    // Test 3: both ports reading every cycle
    $display("[TB] test 3 conflict");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b1, 1'b1, t3Addr0[i], 4'h0, 32'h0);
      applyStimulus(1, 1'b1, 1'b1, t3Addr1[i], 4'h0, 32'h0);
      midCycle();
      checkOutput("t3_ready0", {31'h0, req0Ready}, {31'h0, ~t3Grant[i]});
      checkOutput("t3_ready1", {31'h0, req1Ready}, {31'h0, t3Grant[i]});
      checkOutput("t3_rsp_valid", {31'h0, rspValid}, (i >= 2) ? 32'h1 : 32'h0);
      expQ.push_back('{id: t3Grant[i], data: t3Data[i]});
      nextCycle();
    end
    applyStimulus(0, 1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
    midCycle();
    checkOutput("t3_rsp_valid_c5", {31'h0, rspValid}, 32'h1);
    nextCycle();
    midCycle();
    checkOutput("t3_rsp_valid_c6", {31'h0, rspValid}, 32'h1);
    nextCycle();
    midCycle();
    checkOutput("t3_rsp_valid_c7", {31'h0, rspValid}, 32'h0);
    nextCycle();

    // Test 4: response backpressure
    $display("[TB] test 4 backpressure");
    rspReady = 1'b0;
    applyStimulus(0, 1'b1, 1'b1, 14'h0200, 4'h0, 32'h0);
    midCycle();
    checkOutput("t4_ready0_c1", {31'h0, req0Ready}, 32'h1);
    expQ.push_back('{id: 1'b0, data: 32'hC0C00200});
    nextCycle();
    applyStimulus(0, 1'b1, 1'b1, 14'h0201, 4'h0, 32'h0);
    midCycle();
    checkOutput("t4_ready0_c2", {31'h0, req0Ready}, 32'h1);
    expQ.push_back('{id: 1'b0, data: 32'hC1C10201});
    nextCycle();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1'b1, 1'b1, 14'h0202, 4'h0, 32'h0);
      applyStimulus(1, 1'b1, 1'b0, 14'h0300, 4'hF, 32'h55667788);
      midCycle();
      checkOutput("t4_ready0_stall", {31'h0, req0Ready}, 32'h0);
      checkOutput("t4_ready1_write", {31'h0, req1Ready}, 32'h1);
      checkOutput("t4_sram_we", {28'h0, sramWe}, 32'hF);
      nextCycle();
    end
    applyStimulus(1, 1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
    midCycle();
    checkOutput("t4_ready0_c5", {31'h0, req0Ready}, 32'h0);
    checkOutput("t4_hold_valid", {31'h0, rspValid}, 32'h1);
    checkOutput("t4_hold_id", {31'h0, rspId}, 32'h0);
    checkOutput("t4_hold_data", rspData, 32'hC0C00200);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
    rspReady = 1'b1;
    idle(4);

    // Test 5: zero-enable write leaves memory alone
    $display("[TB] test 5 zero-enable write");
    applyStimulus(0, 1'b1, 1'b0, 14'h0300, 4'h0, 32'hFFFFFFFF);
    midCycle();
    checkOutput("t5_ready0", {31'h0, req0Ready}, 32'h1);
    checkOutput("t5_sram_select", {31'h0, sramSelect}, 32'h0);
    checkOutput("t5_sram_we", {28'h0, sramWe}, 32'h0);
    nextCycle();
    applyStimulus(0, 1'b1, 1'b1, 14'h0300, 4'h0, 32'h0);
    midCycle();
    checkOutput("t5_read_ready0", {31'h0, req0Ready}, 32'h1);
    expQ.push_back('{id: 1'b0, data: 32'h55667788});
    nextCycle();
    idle(4);

    // Test 6: reset with a read in flight and one queued response
    $display("[TB] test 6 reset mid-operation");
    rspReady = 1'b0;
    applyStimulus(0, 1'b1, 1'b1, 14'h0010, 4'h0, 32'h0);
    midCycle();
    checkOutput("t6_ready0_c1", {31'h0, req0Ready}, 32'h1);
    nextCycle();
    applyStimulus(0, 1'b1, 1'b1, 14'h0201, 4'h0, 32'h0);
    midCycle();
    checkOutput("t6_ready0_c2", {31'h0, req0Ready}, 32'h1);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
    midCycle();
    checkOutput("t6_queued_valid", {31'h0, rspValid}, 32'h1);
    resetN = 1'b0;
    #1;
    checkOutput("t6_reset_rsp_valid", {31'h0, rspValid}, 32'h0);
    nextCycle();
    nextCycle();
    resetN   = 1'b1;
    rspReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      midCycle();
      checkOutput("t6_no_stale", {31'h0, rspValid}, 32'h0);
      nextCycle();
    end
    applyStimulus(0, 1'b1, 1'b1, 14'h0010, 4'h0, 32'h0);
    midCycle();
    checkOutput("t6_new_ready0", {31'h0, req0Ready}, 32'h1);
    expQ.push_back('{id: 1'b0, data: 32'hDEADBEEF});
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 14'h0, 4'h0, 32'h0);

    // Bounded drain of anything still expected
    waitCycles = 0;
    while (expQ.size() != 0 && waitCycles < 20) begin
      nextCycle();
      waitCycles++;
    end
    nextCycle();
    checkOutput("drain_left", expQ.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
